// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_src_t;

  localparam int DEFAULT_STEP         = 4;
  localparam int DEFAULT_RESET_VECTOR = 0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty only raises the underflow pulse.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;    // next slot to write; top of stack is ptr-1
  logic [CW-1:0]    count;

  assign top_data = mem[ptr - PTR_ONE];
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);

  // NOTE: non-blocking assignments for every flop so all state moves on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full;
      underflow <= pop && empty;
      if (push) begin
        ptr <= ptr + PTR_ONE;
        if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read after a push.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: priority next-PC select (ret > call > jump > branch > seq).
// The return-address stack is built only when PC_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = DEFAULT_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  pc_src_t          src;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_branch;
  logic [WIDTH-1:0] ras_top;

  assign pc_seq    = pc_out + WIDTH'(STEP);
  assign pc_branch = pc_out + branch_offset;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    src = PC_SEQ;
    if (ret)               src = PC_RET;
    else if (call)         src = PC_CALL;
    else if (jump)         src = PC_JUMP;
    else if (branch_taken) src = PC_BRANCH;
  end

  always_comb begin
    pc_next = pc_seq;
    case (src)
      PC_BRANCH:        pc_next = pc_branch;
      PC_JUMP, PC_CALL: pc_next = jump_target;
      PC_RET:           pc_next = ras_empty ? pc_seq : ras_top;
      default:          pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       pc_out <= RESET_VECTOR;
    else if (enable) pc_out <= pc_next;
  end

`ifdef PC_RAS_EN
  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (enable && (src == PC_CALL)),
    .pop      (enable && (src == PC_RET)),
    .push_data(pc_seq),
    .top_data (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );
`else
  // Without a stack, an always-empty RAS turns call into jump and ret into sequential.
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expectations follow PC_RAS_EN.
`timescale 1ns/1ps
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, branch_taken, jump, call, ret;
  logic [31:0] branch_offset, jump_target;
  logic [31:0] pc_out, pc_next;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
    .pc_out(pc_out), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    branch_taken = 0; jump = 0; call = 0; ret = 0;
    branch_offset = '0; jump_target = '0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump = 1; jump_target = t; step(); jump = 0;
  endtask

  task automatic do_call(input logic [31:0] t);
    call = 1; jump_target = t; step(); call = 0;
  endtask

  initial begin
    reset = 1; enable = 0; idle_req();
    step(); step();
    check("reset_pc", pc_out, 32'h0);
    check("reset_empty", 32'(ras_empty), 32'd1);
    check("reset_full", 32'(ras_full), 32'd0);
    check("reset_ovf", 32'(ras_overflow), 32'd0);
    check("reset_unf", 32'(ras_underflow), 32'd0);

    // Sequential run
    reset = 0; enable = 1;
    #1 check("seq_next", pc_next, 32'h4);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("seq_%0d", i), pc_out, 32'(i * 4));
    end

    // Stall with a pending branch at 'h10
    enable = 0; branch_taken = 1; branch_offset = 32'h8;
    #1 check("stall_next", pc_next, 32'h18);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc_out, 32'h10);
    end
    enable = 1; step();
    check("stall_release", pc_out, 32'h18);
    branch_taken = 0;

    // Reset while stalled
    enable = 0; reset = 1; step();
    check("reset_mid_stall", pc_out, 32'h0);
    reset = 0; enable = 1;

    // Negative branch from 'h10
    for (int i = 0; i < 4; i++) step();
    branch_taken = 1; branch_offset = -32'sd8; step(); branch_taken = 0;
    check("branch_neg", pc_out, 32'h08);

    // Wrap at the top of the address space
    do_jump(32'hFFFF_FFFC);
    check("jump_top", pc_out, 32'hFFFF_FFFC);
    step();
    check("wrap", pc_out, 32'h0);

    // Call/ret pair
    do_jump(32'h20);
    call = 1; jump_target = 32'h100;
    #1 check("call_next", pc_next, 32'h100);
    step(); call = 0;
    check("call_pc", pc_out, 32'h100);
    check("call_empty", 32'(ras_empty), RAS ? 32'd0 : 32'd1);
    ret = 1; step(); ret = 0;
    check("ret_pc", pc_out, RAS ? 32'h24 : 32'h104);
    check("ret_empty", 32'(ras_empty), 32'd1);

    // Five calls into a four-deep stack
    do_jump(32'h0);
    for (int i = 1; i <= 5; i++) begin
      do_call(32'(i * 16));
      check($sformatf("ovf_call_%0d_pc", i), pc_out, 32'(i * 16));
      check($sformatf("ovf_call_%0d_pulse", i), 32'(ras_overflow),
            (RAS && i == 5) ? 32'd1 : 32'd0);
      if (i == 4) check("full_after_4", 32'(ras_full), RAS ? 32'd1 : 32'd0);
    end
    ret = 1;
    step();
    check("ret1_pc", pc_out, RAS ? 32'h44 : 32'h54);
    check("ovf_pulse_drop", 32'(ras_overflow), 32'd0);
    step(); check("ret2_pc", pc_out, RAS ? 32'h34 : 32'h58);
    step(); check("ret3_pc", pc_out, RAS ? 32'h24 : 32'h5C);
    step(); check("ret4_pc", pc_out, RAS ? 32'h14 : 32'h60);
    check("ret4_unf", 32'(ras_underflow), 32'd0);
    step();
    check("ret5_pc", pc_out, RAS ? 32'h18 : 32'h64);
    check("ret5_unf", 32'(ras_underflow), RAS ? 32'd1 : 32'd0);
    ret = 0; step();
    check("unf_pulse_drop", 32'(ras_underflow), 32'd0);
    check("after_unf_pc", pc_out, RAS ? 32'h1C : 32'h68);

    // Priority: ret beats call and jump, pops exactly one entry
    do_call(32'h200);
    do_call(32'h300);
    ret = 1; call = 1; jump = 1; jump_target = 32'h400;
    step(); idle_req();
    check("prio_pc", pc_out, RAS ? 32'h204 : 32'h304);
    check("prio_empty", 32'(ras_empty), RAS ? 32'd0 : 32'd1);
    ret = 1; step(); ret = 0;
    check("prio_ret2_pc", pc_out, RAS ? 32'h20 : 32'h308);
    check("prio_ret2_empty", 32'(ras_empty), 32'd1);

    // Reset during a call
    call = 1; jump_target = 32'h500; reset = 1; step();
    check("reset_mid_call_pc", pc_out, 32'h0);
    check("reset_mid_call_empty", 32'(ras_empty), 32'd1);
    reset = 0; idle_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
